// File: rtl/cone_equiv_runner_pkg.sv
// Shared types and defaults for the cone equivalence runner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cone_equiv_runner_pkg;

  // Run controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Default MISR feedback polynomial and seed (CRC-32 style).
  localparam logic [31:0] SIG_POLY_DEF = 32'h04C11DB7;
  localparam logic [31:0] SIG_SEED_DEF = 32'hFFFFFFFF;

  // A new run may only be launched while no run is active.
  function automatic logic start_ok(input state_t s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/cone_equiv_runner_fifo.sv
// Generic first-word fall-through FIFO with occupancy count.
// Latency: a pushed word is visible on rd_dat the cycle after the push.
// Backpressure: writes are dropped only if full with no pop; callers are expected to hold credit.
module cone_equiv_runner_fifo #(
  parameter int W     = 30,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_vld,
  input  logic [W-1:0]                 wr_dat,
  output logic                         rd_vld,
  input  logic                         rd_rdy,
  output logic [W-1:0]                 rd_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          do_wr;
  logic          do_rd;

  // A pop frees a slot in the same cycle, so a full FIFO may accept a push alongside it.
  assign do_rd  = rd_rdy && (cnt != '0);
  assign do_wr  = wr_vld && ((cnt != FULL) || do_rd);
  assign rd_vld = (cnt != '0);
  assign rd_dat = mem[rptr];
  assign count  = cnt;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Storage array; no reset needed since contents are qualified by the count.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr] <= wr_dat;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) begin
        wptr <= ptr_inc(wptr);
      end
      if (do_rd) begin
        rptr <= ptr_inc(rptr);
      end
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/cone_equiv_runner.sv
// Drives stimulus into two external cones, buffers cone A results, flags A/B divergence, MISR-signs results.
// Latency: result enters the FIFO CONE_LAT cycles after accept and is visible one cycle later.
// Backpressure: res_ready low fills the FIFO; in_ready is withheld once FIFO plus in-flight reach DEPTH.
module cone_equiv_runner
  import cone_equiv_runner_pkg::*;
#(
  parameter int               IN_W     = 50,
  parameter int               OUT_W    = 30,
  parameter int               CONE_LAT = 1,
  parameter int               DEPTH    = 4,
  parameter int               CNT_W    = 16,
  parameter int               SIG_W    = 32,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(SIG_POLY_DEF),
  parameter logic [SIG_W-1:0] SIG_SEED = SIG_W'(SIG_SEED_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic [IN_W-1:0]   cone_in,
  input  logic [OUT_W-1:0]  cone_a,
  input  logic [OUT_W-1:0]  cone_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OUT_W-1:0]  res_data,
  output logic              mismatch,
  output logic [CNT_W-1:0]  mism_idx,
  output logic [SIG_W-1:0]  signature,
  output logic              busy,
  output logic              done
);

  localparam int FCW = $clog2(DEPTH + 1);
  localparam int CRW = FCW + 1;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    num_q;
  logic [CNT_W-1:0]    acc_q;
  logic [CNT_W-1:0]    cap_q;
  logic [CONE_LAT-1:0] tok_q;
  logic [FCW-1:0]      infl_q;
  logic [FCW-1:0]      fifo_cnt;
  logic [SIG_W-1:0]    sig_q;
  logic [SIG_W-1:0]    sig_nxt;
  logic                mism_q;
  logic [CNT_W-1:0]    midx_q;
  logic [CRW-1:0]      credit_used;
  logic                credit_ok;
  logic                start_acc;
  logic                accept;
  logic                capture;

  assign start_acc   = start && start_ok(state_q);
  assign accept      = in_valid && in_ready;
  assign capture     = tok_q[CONE_LAT-1];

  // Every in-flight vector has a reserved FIFO slot, so captures can never be dropped.
  assign credit_used = CRW'(fifo_cnt) + CRW'(infl_q);
  assign credit_ok   = credit_used < CRW'(DEPTH);

  // MISR step: shift left, fold polynomial on carry-out, inject the captured cone A word.
  assign sig_nxt = {sig_q[SIG_W-2:0], 1'b0}
                 ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
                 ^ SIG_W'(cone_a);

  assign mismatch  = mism_q;
  assign mism_idx  = midx_q;
  assign signature = sig_q;

  // Run controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status decode.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        done = (state_q == ST_DONE);
        if (start) begin
          // An empty run completes straight away.
          state_d = (num_vec == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        in_ready = (acc_q < num_q) && credit_ok;
        if (acc_q == num_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if ((infl_q == '0) && (fifo_cnt == '0)) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Valid tokens track each accepted vector through the cone latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_q <= '0;
    end else begin
      tok_q[0] <= accept;
      for (int i = 1; i < CONE_LAT; i++) begin
        tok_q[i] <= tok_q[i-1];
      end
    end
  end

  // In-flight count used for FIFO credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q <= '0;
    end else begin
      case ({accept, capture})
        2'b10:   infl_q <= infl_q + 1'b1;
        2'b01:   infl_q <= infl_q - 1'b1;
        default: infl_q <= infl_q;
      endcase
    end
  end

  // Run bookkeeping: stimulus register, counters, signature and first-mismatch capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cone_in <= '0;
      num_q   <= '0;
      acc_q   <= '0;
      cap_q   <= '0;
      sig_q   <= SIG_SEED;
      mism_q  <= 1'b0;
      midx_q  <= '0;
    end else if (start_acc) begin
      num_q   <= num_vec;
      acc_q   <= '0;
      cap_q   <= '0;
      sig_q   <= SIG_SEED;
      mism_q  <= 1'b0;
      midx_q  <= '0;
    end else begin
      if (accept) begin
        cone_in <= in_data;
        acc_q   <= acc_q + 1'b1;
      end
      if (capture) begin
        sig_q <= sig_nxt;
        cap_q <= cap_q + 1'b1;
        // Only the first divergence of a run is recorded.
        if ((cone_a != cone_b) && !mism_q) begin
          mism_q <= 1'b1;
          midx_q <= cap_q;
        end
      end
    end
  end

  cone_equiv_runner_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (capture),
    .wr_dat (cone_a),
    .rd_vld (res_valid),
    .rd_rdy (res_ready),
    .rd_dat (res_data),
    .count  (fifo_cnt)
  );

endmodule

// File: tb/tb_cone_equiv_runner.sv
// Scoreboard bench for cone_equiv_runner: two instances (cone latency 1 and 3) with modelled cones.
// Latency: n/a.
// Backpressure: res_ready is driven low, high or randomly per instance.
module tb_cone_equiv_runner;
  import cone_equiv_runner_pkg::*;

  localparam int IN_W  = 50;
  localparam int OUT_W = 30;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int SIG_W = 32;
  localparam int NDUT  = 2;
  localparam logic [SIG_W-1:0] POLY = 32'h04C11DB7;
  localparam logic [SIG_W-1:0] SEED = 32'hFFFFFFFF;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start     [NDUT];
  logic [CNT_W-1:0] num_vec   [NDUT];
  logic             in_valid  [NDUT];
  logic             in_ready  [NDUT];
  logic [IN_W-1:0]  in_data   [NDUT];
  logic [IN_W-1:0]  cone_in   [NDUT];
  logic [OUT_W-1:0] cone_a    [NDUT];
  logic [OUT_W-1:0] cone_b    [NDUT];
  logic             res_valid [NDUT];
  logic             res_ready [NDUT];
  logic [OUT_W-1:0] res_data  [NDUT];
  logic             mismatch  [NDUT];
  logic [CNT_W-1:0] mism_idx  [NDUT];
  logic [SIG_W-1:0] signature [NDUT];
  logic             busy      [NDUT];
  logic             done      [NDUT];

  int checks   = 0;
  int failures = 0;

  logic [OUT_W-1:0] expq [NDUT][$];
  logic [IN_W-1:0]  mvec [$];
  int               rr_mode  [NDUT] = '{1, 1};
  logic             held     [NDUT] = '{1'b0, 1'b0};
  logic [OUT_W-1:0] held_dat [NDUT];

  always #5 clk = ~clk;

  cone_equiv_runner #(
    .IN_W(IN_W), .OUT_W(OUT_W), .CONE_LAT(1), .DEPTH(DEPTH), .CNT_W(CNT_W), .SIG_W(SIG_W)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .num_vec(num_vec[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .cone_in(cone_in[0]), .cone_a(cone_a[0]), .cone_b(cone_b[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(res_data[0]),
    .mismatch(mismatch[0]), .mism_idx(mism_idx[0]), .signature(signature[0]),
    .busy(busy[0]), .done(done[0])
  );

  cone_equiv_runner #(
    .IN_W(IN_W), .OUT_W(OUT_W), .CONE_LAT(3), .DEPTH(DEPTH), .CNT_W(CNT_W), .SIG_W(SIG_W)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .num_vec(num_vec[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .cone_in(cone_in[1]), .cone_a(cone_a[1]), .cone_b(cone_b[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(res_data[1]),
    .mismatch(mismatch[1]), .mism_idx(mism_idx[1]), .signature(signature[1]),
    .busy(busy[1]), .done(done[1])
  );

  // Cone models: A passes the low bits, B flips bit 0 when the vector's top bit is set.
  for (genvar g = 0; g < NDUT; g++) begin : g_cone
    logic [IN_W-1:0] dly [2];
    logic [IN_W-1:0] tap;
    always @(posedge clk) begin
      dly[0] <= cone_in[g];
      dly[1] <= dly[0];
    end
    if (g == 0) begin : g_l1
      assign tap = cone_in[g];
    end else begin : g_l3
      assign tap = dly[1];
    end
    assign cone_a[g] = tap[OUT_W-1:0];
    assign cone_b[g] = tap[OUT_W-1:0] ^ {{(OUT_W-1){1'b0}}, tap[IN_W-1]};
  end

  task automatic chk(input int d, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
    end
  endtask

  // res_ready driver: 0 = low, 1 = high, otherwise random.
  initial begin
    res_ready[0] = 1'b0;
    res_ready[1] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
        case (rr_mode[d])
          0:       res_ready[d] = 1'b0;
          1:       res_ready[d] = 1'b1;
          default: res_ready[d] = ($urandom_range(0, 3) != 0);
        endcase
      end
    end
  end

  task automatic mon_step(input int d);
    logic [OUT_W-1:0] e;
    if (!rst_n) begin
      held[d] = 1'b0;
      return;
    end
    if (held[d]) begin
      chk(d, "hold_valid", res_valid[d], 1);
      chk(d, "hold_data", res_data[d], held_dat[d]);
    end
    held[d] = 1'b0;
    if (res_valid[d]) begin
      if (res_ready[d]) begin
        chk(d, "result_expected", expq[d].size() > 0, 1);
        if (expq[d].size() > 0) begin
          e = expq[d].pop_front();
          chk(d, "res_data", res_data[d], e);
        end
      end else begin
        held[d]     = 1'b1;
        held_dat[d] = res_data[d];
      end
    end
  endtask

  // Monitor: compares each handshaken result against the scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) mon_step(d);
  end

  function automatic logic [IN_W-1:0] rvec();
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[IN_W-1] = ($urandom_range(0, 5) == 0);
    return r[IN_W-1:0];
  endfunction

  task automatic chk_reset(input int d);
    chk(d, "rst_cone_in", cone_in[d], 0);
    chk(d, "rst_mismatch", mismatch[d], 0);
    chk(d, "rst_mism_idx", mism_idx[d], 0);
    chk(d, "rst_signature", signature[d], SEED);
    chk(d, "rst_busy", busy[d], 0);
    chk(d, "rst_done", done[d], 0);
    chk(d, "rst_in_ready", in_ready[d], 0);
    chk(d, "rst_res_valid", res_valid[d], 0);
  endtask

  task automatic pulse_start(input int d, input int n);
    @(posedge clk);
    #1;
    start[d]   = 1'b1;
    num_vec[d] = n[CNT_W-1:0];
    @(posedge clk);
    #1;
    start[d] = 1'b0;
  endtask

  // Entered and left just after a rising edge.
  task automatic send(input int d, input logic [IN_W-1:0] v, input int gap);
    int t;
    t = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_data[d]  = v;
    in_valid[d] = 1'b1;
    @(negedge clk);
    while (!in_ready[d] && t < 300) begin
      t++;
      @(negedge clk);
    end
    chk(d, "in_ready_accept", in_ready[d], 1);
    if (in_ready[d]) expq[d].push_back(v[OUT_W-1:0]);
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int t;
    t = 0;
    @(negedge clk);
    while (!done[d] && t < 2000) begin
      t++;
      @(negedge clk);
    end
    chk(d, "done", done[d], 1);
  endtask

  // Reference: signature over the low OUT_W bits of each vector; first flagged vector is the mismatch.
  task automatic check_run(input int d);
    logic [SIG_W-1:0] s;
    logic             m;
    int               idx;
    s   = SEED;
    m   = 1'b0;
    idx = 0;
    foreach (mvec[i]) begin
      s = (s << 1) ^ ((s >= 32'h8000_0000) ? POLY : 32'h0) ^ SIG_W'(mvec[i] % (64'd1 << OUT_W));
      if (!m && mvec[i][IN_W-1]) begin
        m   = 1'b1;
        idx = i;
      end
    end
    chk(d, "signature", signature[d], s);
    chk(d, "mismatch", mismatch[d], m);
    if (m) chk(d, "mism_idx", mism_idx[d], idx);
    chk(d, "busy_after_done", busy[d], 0);
    chk(d, "res_valid_after_done", res_valid[d], 0);
    chk(d, "results_outstanding", expq[d].size(), 0);
  endtask

  task automatic run_vecs(input int d, input int gapmax);
    pulse_start(d, mvec.size());
    foreach (mvec[i]) send(d, mvec[i], $urandom_range(0, gapmax));
    wait_done(d);
    check_run(d);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0] inj;
    logic            stall;
    inj = '0;
    inj[IN_W-1] = 1'b1;
    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      start[d]    = 1'b0;
      num_vec[d]  = '0;
      in_valid[d] = 1'b0;
      in_data[d]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk);
    rst_n = 1'b1;

    // Three plain vectors in order.
    mvec = '{50'd0, 50'd1, 50'd2};
    run_vecs(0, 0);
    chk(0, "t1_done_level", done[0], 1);

    // Divergence on index 1 and again on index 2; first one sticks.
    mvec = '{50'd0, inj | 50'd1, inj | 50'd2};
    run_vecs(0, 0);
    chk(0, "t2_first_idx", mism_idx[0], 1);

    // Empty run: completes on the next cycle with a freshly seeded signature.
    pulse_start(0, 0);
    @(negedge clk);
    chk(0, "t4_done", done[0], 1);
    chk(0, "t4_busy", busy[0], 0);
    chk(0, "t4_signature", signature[0], SEED);
    chk(0, "t4_mismatch", mismatch[0], 0);
    repeat (3) begin
      @(negedge clk);
      chk(0, "t4_no_result", res_valid[0], 0);
    end

    // Single vector 1: (FFFFFFFE ^ 04C11DB7) = FB3EE249, then ^ 1 from cone A.
    mvec = '{50'd1};
    run_vecs(0, 0);
    chk(0, "t5_signature", signature[0], 32'hFB3EE248);

    // Back-pressure: four accepts fill the credit, nothing more until results drain.
    rr_mode[0] = 0;
    @(posedge clk);
    #1;
    mvec.delete();
    for (int i = 0; i < 8; i++) mvec.push_back(rvec());
    pulse_start(0, 8);
    for (int i = 0; i < 4; i++) send(0, mvec[i], 0);
    stall = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (in_ready[0]) stall = 1'b1;
    end
    chk(0, "t3_credit_stall", stall, 0);
    chk(0, "t3_head_valid", res_valid[0], 1);
    rr_mode[0] = 1;
    @(posedge clk);
    #1;
    for (int i = 4; i < 8; i++) send(0, mvec[i], 0);
    wait_done(0);
    check_run(0);

    // Asynchronous reset in the middle of a run.
    rr_mode[0] = 0;
    @(posedge clk);
    #1;
    mvec.delete();
    for (int i = 0; i < 5; i++) mvec.push_back(rvec());
    pulse_start(0, 5);
    send(0, mvec[0], 0);
    send(0, mvec[1], 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    expq[0].delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rr_mode[0] = 1;
    mvec.delete();
    for (int i = 0; i < 6; i++) mvec.push_back(rvec());
    run_vecs(0, 2);

    // Cone latency 3 instance: same vector sets as the first two runs.
    mvec = '{50'd0, 50'd1, 50'd2};
    run_vecs(1, 0);
    mvec = '{50'd0, inj | 50'd1, inj | 50'd2};
    run_vecs(1, 0);
    chk(1, "lat3_first_idx", mism_idx[1], 1);

    // Randomised runs with random gaps and random result back-pressure.
    for (int r = 0; r < 8; r++) begin
      int d;
      d = r % NDUT;
      rr_mode[d] = 2;
      mvec.delete();
      for (int i = 0; i < $urandom_range(1, 20); i++) mvec.push_back(rvec());
      run_vecs(d, 3);
      rr_mode[d] = 1;
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
